// File: rtl/fc_mac_scheduler.sv
// ---------------------------------------------------------------------------
// fc_mac_scheduler
//
// Sequencer for the fully-connected MAC datapath.  For every output group g
// (0..OUTNEURON/PO-1) it streams INNEURON/2 dual-port address pairs (beat k)
// to the input-neuron and weight memories.  It then lets the MAC pipeline
// drain for MAC_LAT cycles and pulses the output-neuron write for group g.
// When the last group has been written, it raises done for one cycle.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; aborts any layer in progress
//   start        begin a layer (only looked at while idle)
//   stall        holds address issue while high (ignored outside ISSUE)
//   busy         high from the cycle after start is accepted through DONE
//   done         one-cycle pulse when the layer is complete
//   rden         read enable for both memories, both ports
//   in_addr_a/b  input-neuron addresses 2k / 2k+1
//   w_addr_a/b   weight addresses g*INNEURON + 2k / +1
//   mac_valid    accumulator input valid (rden delayed by MAC_LAT)
//   accum_sload  accumulator load (instead of add) on beat 0 of a group
//   out_wren     one-cycle write strobe for the group result
//   out_addr     group index, valid with out_wren
// ---------------------------------------------------------------------------
module fc_mac_scheduler #(
    parameter int INNEURON       = 64,
    parameter int OUTNEURON      = 16,
    parameter int PO             = 4,
    parameter int MAC_LAT        = 3,
    parameter int IN_ADDR_WIDTH  = 6,
    parameter int W_ADDR_WIDTH   = 8,
    parameter int OUT_ADDR_WIDTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      rden,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr_a,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr_b,
    output logic [W_ADDR_WIDTH-1:0]   w_addr_a,
    output logic [W_ADDR_WIDTH-1:0]   w_addr_b,
    output logic                      mac_valid,
    output logic                      accum_sload,
    output logic                      out_wren,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr
);

    localparam int BEATS  = INNEURON / 2;
    localparam int GROUPS = OUTNEURON / PO;
    localparam int K_W    = (BEATS > 1)   ? $clog2(BEATS)   : 1;
    localparam int G_W    = (GROUPS > 1)  ? $clog2(GROUPS)  : 1;
    localparam int D_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [K_W-1:0] K_LAST = K_W'(BEATS - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [G_W-1:0]     g_q, g_d;
    logic [D_W-1:0]     drain_q, drain_d;
    logic [MAC_LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [MAC_LAT-1:0] pipe_first_q, pipe_first_d;

    logic issuing;
    logic issue_beat;

    assign issuing    = (state_q == S_ISSUE);
    assign issue_beat = issuing && !stall;

    // Next-state and counter logic.  k and g only advance below their
    // maxima; they are cleared explicitly when a new group/layer begins.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    g_d     = '0;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == D_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (g_q == G_LAST) begin
                    state_d = S_DONE;
                end else begin
                    g_d     = g_q + 1'b1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // MAC_LAT-deep tag pipeline.  It shifts every cycle regardless of state
    // or stall, so a stalled cycle simply injects a bubble and data already
    // in flight keeps moving toward the accumulator.
    genvar gi;
    generate
        for (gi = 0; gi < MAC_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_valid_d[gi] = issue_beat;
                assign pipe_first_d[gi] = issue_beat && (k_q == '0);
            end else begin : g_body
                assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
                assign pipe_first_d[gi] = pipe_first_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            g_q          <= '0;
            drain_q      <= '0;
            pipe_valid_q <= '0;
            pipe_first_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            g_q          <= g_d;
            drain_q      <= drain_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_first_q <= pipe_first_d;
        end
    end

    // Address generation.  Addresses follow the registered k/g while in
    // ISSUE (so they hold steady through a stall) and read as zero in every
    // other state, which keeps the bus quiet when idle or after reset.
    logic [IN_ADDR_WIDTH-1:0] in_even;
    logic [W_ADDR_WIDTH-1:0]  w_base;
    logic [W_ADDR_WIDTH-1:0]  w_even;

    assign in_even = IN_ADDR_WIDTH'(k_q) << 1;
    assign w_base  = W_ADDR_WIDTH'(g_q) * W_ADDR_WIDTH'(INNEURON);
    assign w_even  = w_base + (W_ADDR_WIDTH'(k_q) << 1);

    // INNEURON is even, so the A-port address is always even and the
    // B-port address is obtained by setting bit 0.
    assign in_addr_a = issuing ? in_even : '0;
    assign in_addr_b = issuing ? (in_even | IN_ADDR_WIDTH'(1)) : '0;
    assign w_addr_a  = issuing ? w_even : '0;
    assign w_addr_b  = issuing ? (w_even | W_ADDR_WIDTH'(1)) : '0;

    assign rden        = issue_beat;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign out_wren    = (state_q == S_WRITE);
    assign out_addr    = out_wren ? OUT_ADDR_WIDTH'(g_q) : '0;
    assign mac_valid   = pipe_valid_q[MAC_LAT-1];
    assign accum_sload = pipe_valid_q[MAC_LAT-1] & pipe_first_q[MAC_LAT-1];

endmodule
